// File: rtl/text_render_ctrl.sv
// -----------------------------------------------------------------------------
// text_render_ctrl
//
// Purpose:
//   Text-mode rendering sequencer for an 80x30 character display on a
//   640x480 visible VGA raster. The VGA pixel coordinates are turned into a
//   text-buffer read address. The returned character drives the glyph ROM
//   lookup. The selected glyph bit becomes a per-pixel on/off value. Each
//   cell may be drawn in inverse video, and a blinking underline cursor is
//   overlaid on glyph rows 14-15 of the cursor cell.
//
//   Two pipeline stages advance only on pixel_tick:
//     Stage A : latch text address, glyph column/row, visible flag and cursor
//               hit for the presented coordinate.
//     Stage B : pick the glyph bit, apply inverse/underline, register the
//               pixel and the matching visible flag.
//   The outputs therefore describe the coordinate presented two ticks before.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous active-high reset
//   i_pixel_tick   pixel enable (never high on two consecutive clocks)
//   i_pixel_x      pixel column 0-799
//   i_pixel_y      pixel line 0-524
//   i_video_on     visible-area flag for (i_pixel_x, i_pixel_y)
//   o_text_addr    text buffer read address = row*COLS + col
//   i_text_data    text buffer data: [6:0] character code, [7] inverse flag
//   o_char_code    character ROM code (combinational from i_text_data)
//   o_char_row     character ROM glyph row (from stage A)
//   i_char_line    character ROM line, bit 7 = leftmost pixel
//   i_cursor_en    cursor enable
//   i_cursor_col   cursor column
//   i_cursor_row   cursor row
//   o_pixel_on     foreground pixel, aligned with o_video_out
//   o_video_out    i_video_on delayed to match o_pixel_on
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module text_render_ctrl #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pixel_tick,
  input  logic [9:0]  i_pixel_x,
  input  logic [9:0]  i_pixel_y,
  input  logic        i_video_on,
  output logic [11:0] o_text_addr,
  input  logic [7:0]  i_text_data,
  output logic [6:0]  o_char_code,
  output logic [3:0]  o_char_row,
  input  logic [7:0]  i_char_line,
  input  logic        i_cursor_en,
  input  logic [6:0]  i_cursor_col,
  input  logic [4:0]  i_cursor_row,
  output logic        o_pixel_on,
  output logic        o_video_out
);

  // Frame counter only has to reach BLINK_FRAMES-1 (BLINK_FRAMES >= 2).
  localparam int                CNT_W      = $clog2(BLINK_FRAMES);
  localparam logic [CNT_W-1:0]  BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [11:0]       COLS_W     = 12'(COLS);

  // ---------------------------------------------------------------------------
  // Coordinate decode
  // ---------------------------------------------------------------------------
  logic [6:0]  w_cell_col;
  logic [4:0]  w_cell_row;
  logic [11:0] w_row_base;
  logic [11:0] w_cell_addr;
  logic        w_cur_col_ok;
  logic        w_cur_row_ok;
  logic        w_cur_hit;
  logic        w_frame_start;

  assign w_cell_col = i_pixel_x[9:3];
  assign w_cell_row = i_pixel_y[8:4];

  // 12-bit product is enough: the largest address is 29*80+79 = 2399.
  assign w_row_base  = {7'd0, w_cell_row} * COLS_W;
  assign w_cell_addr = w_row_base + {5'd0, w_cell_col};

  // A cursor parked outside the text grid must never light a cell, even if
  // its truncated coordinates alias an off-screen raster position.
  assign w_cur_col_ok = (int'(i_cursor_col) < COLS);
  assign w_cur_row_ok = (int'(i_cursor_row) < ROWS);
  assign w_cur_hit    = i_cursor_en & w_cur_col_ok & w_cur_row_ok &
                        (w_cell_col == i_cursor_col) &
                        (w_cell_row == i_cursor_row);

  // First visible pixel of a frame advances the blink counter.
  assign w_frame_start = i_pixel_tick & i_video_on &
                         (i_pixel_x == 10'd0) & (i_pixel_y == 10'd0);

  // ---------------------------------------------------------------------------
  // Stage A registers
  // ---------------------------------------------------------------------------
  logic [11:0] r_text_addr;
  logic [2:0]  r_a_col;
  logic [3:0]  r_a_row;
  logic        r_a_vid;
  logic        r_a_cur;
  logic [11:0] w_addr_next;

  // Blank regions read address 0 so the buffer sees a quiet, fixed address.
  always_comb begin
    w_addr_next = 12'd0;
    if (i_video_on) begin
      w_addr_next = w_cell_addr;
    end else begin
      w_addr_next = 12'd0;
    end
  end

  // Stage A: capture the address and per-pixel cell context on each tick.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_text_addr <= 12'd0;
      r_a_col     <= 3'd0;
      r_a_row     <= 4'd0;
      r_a_vid     <= 1'b0;
      r_a_cur     <= 1'b0;
    end else if (i_pixel_tick) begin
      r_text_addr <= w_addr_next;
      r_a_col     <= i_pixel_x[2:0];
      r_a_row     <= i_pixel_y[3:0];
      r_a_vid     <= i_video_on;
      r_a_cur     <= w_cur_hit;
    end
  end

  assign o_text_addr = r_text_addr;

  // ROM lookup is driven straight from the buffer data and stage A row.
  assign o_char_code = i_text_data[6:0];
  assign o_char_row  = r_a_row;

  // ---------------------------------------------------------------------------
  // Cursor blink
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_blink_phase;

  // Blink timer: counts frames and flips the cursor phase every half-period.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (w_frame_start) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage B: glyph bit select, inverse, underline
  // ---------------------------------------------------------------------------
  logic [2:0] w_bit_sel;
  logic       w_glyph;
  logic       w_underline;
  logic       w_pixel_next;
  logic       r_pixel_on;
  logic       r_video_out;

  // Bit 7 of the ROM line is the leftmost pixel of the cell.
  assign w_bit_sel = 3'd7 - r_a_col;
  assign w_glyph   = i_char_line[w_bit_sel];

  // Underline sits on the bottom two glyph rows; it is OR-ed after the
  // inversion so an inverse cell still shows the cursor.
  assign w_underline  = r_a_cur & r_blink_phase & (r_a_row >= 4'd14);
  assign w_pixel_next = r_a_vid & ((w_glyph ^ i_text_data[7]) | w_underline);

  // Stage B: register the final pixel and its aligned visible flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pixel_on  <= 1'b0;
      r_video_out <= 1'b0;
    end else if (i_pixel_tick) begin
      r_pixel_on  <= w_pixel_next;
      r_video_out <= r_a_vid;
    end
  end

  assign o_pixel_on  = r_pixel_on;
  assign o_video_out = r_video_out;

endmodule

// File: doc/text_render_ctrl.md
Name: text_render_ctrl

Overview:
- Sequences the 80x30 text-mode display path: converts VGA pixel coordinates into text-buffer reads, drives the character ROM lookup (7-bit code, 4-bit glyph row), and serializes the returned 8-bit glyph line into a per-pixel on/off stream.
- Adds per-character inverse video and a blinking underline cursor.
- Sits between the VGA sync generator, the text buffer RAM and the character ROM; feeds the colour mux.

Parameters:
- COLS, 80, characters per text row.
- ROWS, 30, text rows.
- BLINK_FRAMES, 30, frames per cursor blink half-period; must be at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pixel_tick  in  1  pixel enable. Never high on two consecutive clk cycles.
- pixel_x  in  10  current pixel column, 0-799.
- pixel_y  in  10  current pixel line, 0-524.
- video_on  in  1  visible-area flag for (pixel_x, pixel_y).
- text_addr  out  12  text buffer read address, row*COLS+col.
- text_data  in  8  text buffer data: [6:0] ASCII code, [7] inverse flag. Valid one clk after text_addr changes.
- char_code  out  7  character ROM code.
- char_row  out  4  character ROM glyph row.
- char_line  in  8  ROM line; bit 7 is the leftmost pixel. Combinational from char_code/char_row.
- cursor_en  in  1  cursor enable.
- cursor_col  in  7  cursor column.
- cursor_row  in  5  cursor row.
- pixel_on  out  1  foreground pixel, aligned with video_out.
- video_out  out  1  video_on delayed to match pixel_on.

Behaviour:
- Reset (synchronous, active-high): all pipeline registers, text_addr, pixel_on and video_out go to 0; blink counter goes to 0; blink_phase goes to 1 (cursor visible). Reset overrides pixel_tick in the same cycle. Reset mid-frame drops pixel_on/video_out to 0 until two ticks have refilled the pipeline.
- Pipeline advances only on clk edges where pixel_tick=1. Otherwise all registers hold.
- Stage A (tick):
  - If video_on=1: text_addr <= pixel_y[8:4]*COLS + pixel_x[9:3].
  - If video_on=0: text_addr <= 0.
  - a_col <= pixel_x[2:0]; a_row <= pixel_y[3:0]; a_vid <= video_on.
  - a_cur <= cursor_en & (pixel_x[9:3]==cursor_col) & (pixel_y[8:4]==cursor_row).
- ROM drive (combinational): char_code = text_data[6:0]; char_row = a_row.
- Stage B (tick):
  - glyph = char_line[7-a_col].
  - ul = a_cur & blink_phase & (a_row>=14).
  - pixel_on <= a_vid & ((glyph ^ text_data[7]) | ul).
  - video_out <= a_vid.
- Latency: pixel_on/video_out reflect the coordinates presented exactly 2 ticks earlier.
- Width rule: row*80 is computed in 12 bits. Maximum address is 29*80+79 = 2399, so no overflow.
- Blink: on a tick with pixel_x==0, pixel_y==0 and video_on=1, the frame counter increments.
  - When the counter reaches BLINK_FRAMES-1, it wraps to 0 and blink_phase toggles.
  - blink_phase is sampled by Stage B. A toggle mid-pixel applies from the next tick.
- Cursor coordinates outside 0..COLS-1 / 0..ROWS-1 never match, so no cursor is drawn.
- Inverse cell (text_data[7]=1) with the cursor visible: underline rows 14-15 are forced on; it does not cancel the inversion.
- No handshake: ROM and text buffer are always ready. The block never stalls.

Test Plan:
- Reset with pixel_tick toggling -> pixel_on=0, video_out=0, text_addr=0 for the whole reset; first valid pixel_on appears exactly 2 ticks after reset is released.
- pixel_x=17, pixel_y=35, video_on=1, one tick -> text_addr=2*80+2=162, char_row=3. Then text_data=0x41 and char_line=0x18; tick at x=19 (a_col=3) -> pixel_on=1; at a_col=0 -> pixel_on=0.
- Last visible cell: x=639, y=479 -> text_addr=2399, char_row=15. With video_on=0 at x=700 -> text_addr=0, and pixel_on=0 two ticks later regardless of char_line.
- Inverse: text_data=0xC1 with char_line=0x18 -> pixel_on equals the complement of the glyph bits across a_col 0-7: 1,1,1,0,0,1,1,1.
- Cursor: cursor_en=1, cursor_col=5, cursor_row=2, text_data=0x20, char_line=0x00.
  - Rows y=46,47 in x=40..47 -> pixel_on=1 while blink_phase=1.
  - Row y=45 -> pixel_on=0.
  - cursor_en=0 -> pixel_on=0 on all rows.
- Blink: drive 30 frame-origin ticks -> blink_phase toggles 1->0 after the 30th, back to 1 after the 60th; underline absent during the 0 phase. A cursor at col 90 never draws.
